// File: rtl/mult_share_pkg.sv
// Shared types and sizing for the two-requester multiplier sharing arbiter.
// Operand/product widths and default timing of the shared multiplier.
package mult_share_pkg;

    localparam int OP_W            = 32;
    localparam int PROD_W          = 64;
    localparam int LOAD_CYCLES_DEF = 3;
    localparam int MUL_CYCLES_DEF  = 17;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Two-way round-robin grant: on a tie the requester that was not
// granted last wins; a lone request always wins.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o,
    output logic       any_o
);

    always_comb begin
        grant_id_o = 1'b0;
        unique case (req_i)
            2'b00: grant_id_o = 1'b0;
            2'b01: grant_id_o = 1'b0;
            2'b10: grant_id_o = 1'b1;
            2'b11: grant_id_o = ~last_grant_i;
            default: grant_id_o = 1'b0;
        endcase
        any_o   = |req_i;
        grant_o = 2'b00;
        if (any_o) begin
            grant_o = grant_id_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Time-shares one multi-cycle multiplier between two requesters:
// arbitrate, load operands, wait for the product, hand it back.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int LOAD_CYCLES = LOAD_CYCLES_DEF,
    parameter int MUL_CYCLES  = MUL_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*OP_W-1:0]   req_m,
    input  logic [2*OP_W-1:0]   req_q,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [PROD_W-1:0]   resp_product,
    output logic                mul_load,
    output logic [OP_W-1:0]     mul_m,
    output logic [OP_W-1:0]     mul_q,
    input  logic [PROD_W-1:0]   mul_product,
    output logic                busy
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);
    localparam int LD_W  = $clog2(LOAD_CYCLES + 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(LOAD_CYCLES - 1);

    state_e              state_q, state_d;
    logic [LD_W-1:0]     ld_cnt_q, ld_cnt_d;
    logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
    logic [OP_W-1:0]     mul_m_q, mul_m_d;
    logic [OP_W-1:0]     mul_q_q, mul_q_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                resp_id_q, resp_id_d;
    logic [PROD_W-1:0]   resp_prod_q, resp_prod_d;

    logic [1:0]          arb_grant;
    logic                arb_id;
    logic                arb_any;

    rr_arbiter2 u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .grant_id_o   (arb_id),
        .any_o        (arb_any)
    );

    always_comb begin
        state_d      = state_q;
        ld_cnt_d     = ld_cnt_q;
        run_cnt_d    = run_cnt_q;
        mul_m_d      = mul_m_q;
        mul_q_d      = mul_q_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        resp_id_d    = resp_id_q;
        resp_prod_d  = resp_prod_q;
        req_ready    = 2'b00;
        unique case (state_q)
            IDLE: begin
                // Grant is suppressed while reset is held so nothing is accepted.
                if (arb_any && !reset) begin
                    req_ready = arb_grant;
                    owner_d   = arb_id;
                    mul_m_d   = arb_id ? req_m[2*OP_W-1:OP_W] : req_m[OP_W-1:0];
                    mul_q_d   = arb_id ? req_q[2*OP_W-1:OP_W] : req_q[OP_W-1:0];
                    ld_cnt_d  = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (ld_cnt_q == LD_LAST) begin
                    ld_cnt_d  = '0;
                    run_cnt_d = '0;
                    state_d   = RUN;
                end else begin
                    ld_cnt_d = ld_cnt_q + LD_W'(1);
                end
            end
            RUN: begin
                if (run_cnt_q == RUN_LAST) begin
                    run_cnt_d   = '0;
                    resp_prod_d = mul_product;
                    resp_id_d   = owner_q;
                    state_d     = DONE;
                end else begin
                    run_cnt_d = run_cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (resp_ready) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ld_cnt_q     <= '0;
            run_cnt_q    <= '0;
            mul_m_q      <= '0;
            mul_q_q      <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            resp_id_q    <= 1'b0;
            resp_prod_q  <= '0;
        end else begin
            state_q      <= state_d;
            ld_cnt_q     <= ld_cnt_d;
            run_cnt_q    <= run_cnt_d;
            mul_m_q      <= mul_m_d;
            mul_q_q      <= mul_q_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            resp_id_q    <= resp_id_d;
            resp_prod_q  <= resp_prod_d;
        end
    end

    assign mul_load     = (state_q == IDLE) || (state_q == LOAD);
    assign busy         = (state_q != IDLE);
    assign resp_valid   = (state_q == DONE);
    assign resp_id      = resp_id_q;
    assign resp_product = resp_prod_q;
    assign mul_m        = mul_m_q;
    assign mul_q        = mul_q_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scenario bench for mult_share_arbiter with a behavioural multi-cycle
// multiplier and a queue of expected responses.
module tb_mult_share_arbiter;

    localparam int LOAD_CYCLES = 3;
    localparam int MUL_CYCLES  = 17;
    localparam int LAT         = 1 + LOAD_CYCLES + MUL_CYCLES;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [63:0] req_m = '0;
    logic [63:0] req_q = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_id;
    logic [63:0] resp_product;
    logic        mul_load;
    logic [31:0] mul_m;
    logic [31:0] mul_q;
    logic [63:0] mul_product;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int g_cyc = 0;
    int r_cyc = 0;

    typedef struct packed {
        logic        id;
        logic [63:0] prod;
    } exp_t;
    exp_t sb[$];

    mult_share_arbiter #(
        .LOAD_CYCLES (LOAD_CYCLES),
        .MUL_CYCLES  (MUL_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_m        (req_m),
        .req_q        (req_q),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .mul_load     (mul_load),
        .mul_m        (mul_m),
        .mul_q        (mul_q),
        .mul_product  (mul_product),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb_;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        return 64'(sa * sb_);
    endfunction

    // Multiplier model: result only valid in the MUL_CYCLES-th cycle out of load.
    int mcnt = 0;
    always @(posedge clk) begin
        if (mul_load) mcnt <= 0;
        else if (mcnt < 1000) mcnt <= mcnt + 1;
    end
    always_comb begin
        mul_product = 64'hDEAD_BEEF_0BAD_F00D;
        if (!mul_load && mcnt >= MUL_CYCLES - 1) mul_product = smul(mul_m, mul_q);
    end

    function automatic exp_t mk_exp(input logic id);
        exp_t e;
        e.id   = id;
        e.prod = id ? smul(req_m[63:32], req_q[63:32]) : smul(req_m[31:0], req_q[31:0]);
        return e;
    endfunction

    task automatic wait_grant(output int gid, output bit ok);
        ok  = 1'b0;
        gid = -1;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (req_ready != 2'b00) begin
                ok    = 1'b1;
                gid   = req_ready[1] ? 1 : 0;
                g_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (resp_valid) begin
                ok    = 1'b1;
                r_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 2'b11;
        req_m     = 64'h1234_5678_9ABC_DEF0;
        req_q     = 64'h0FED_CBA9_8765_4321;
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b want 00", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL rst_resp_id got %b want 0", resp_id); end
        checks++; if (resp_product !== 64'd0) begin errors++; $display("FAIL rst_resp_product got %h want 0", resp_product); end
        checks++; if (mul_m !== 32'd0) begin errors++; $display("FAIL rst_mul_m got %h want 0", mul_m); end
        checks++; if (mul_q !== 32'd0) begin errors++; $display("FAIL rst_mul_q got %h want 0", mul_q); end
        checks++; if (mul_load !== 1'b1) begin errors++; $display("FAIL rst_mul_load got %b want 1", mul_load); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        req_valid = 2'b00;
    endtask

    task automatic test_single();
        int gid;
        bit ok;
        exp_t e;
        @(negedge clk);
        reset     = 1'b0;
        req_m     = {32'hCAFE_0001, 32'h0008_7234};
        req_q     = {32'h0000_0007, 32'h0000_0348};
        req_valid = 2'b01;
        wait_grant(gid, ok);
        checks++; if (!ok || gid != 0) begin errors++; $display("FAIL single_grant got %0d want 0", gid); end
        sb.push_back(mk_exp(1'b0));
        @(negedge clk);
        req_valid = 2'b00;
        req_m     = '0;
        req_q     = '0;
        #1;
        checks++; if (mul_m !== 32'h0008_7234 || mul_q !== 32'h0000_0348) begin
            errors++; $display("FAIL single_operands got %h/%h want 00087234/00000348", mul_m, mul_q);
        end
        checks++; if (busy !== 1'b1 || mul_load !== 1'b1) begin
            errors++; $display("FAIL single_load busy=%b load=%b want 1/1", busy, mul_load);
        end
        wait_resp(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_resp_timeout got none want resp"); end
        e = sb.pop_front();
        checks++; if (resp_id !== e.id) begin errors++; $display("FAIL single_id got %b want %b", resp_id, e.id); end
        checks++; if (resp_product !== e.prod || resp_product !== 64'h0000_0000_1BB6_BAA0) begin
            errors++; $display("FAIL single_product got %h want %h", resp_product, e.prod);
        end
        checks++; if (r_cyc - g_cyc != LAT) begin errors++; $display("FAIL single_latency got %0d want %0d", r_cyc - g_cyc, LAT); end
        handshake();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_after_hs valid=%b busy=%b want 0/0", resp_valid, busy);
        end
    endtask

    task automatic test_tie();
        int gid;
        bit ok;
        exp_t e;
        @(negedge clk);
        reset     = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        req_m     = {32'hFFFF_FEFD, 32'h1234_5678};
        req_q     = {32'hFFFF_FEFD, 32'hFFFF_FFF0};
        req_valid = 2'b11;
        wait_grant(gid, ok);
        checks++; if (!ok || gid != 0) begin errors++; $display("FAIL tie_first got %0d want 0", gid); end
        sb.push_back(mk_exp(1'b0));
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL tie_busy_ready got %b want 00", req_ready); end
        wait_resp(ok);
        e = sb.pop_front();
        checks++; if (!ok || resp_id !== e.id || resp_product !== e.prod) begin
            errors++; $display("FAIL tie_resp0 got %b/%h want %b/%h", resp_id, resp_product, e.id, e.prod);
        end
        handshake();
        wait_grant(gid, ok);
        checks++; if (!ok || gid != 1) begin errors++; $display("FAIL tie_second got %0d want 1", gid); end
        sb.push_back(mk_exp(1'b1));
        @(negedge clk);
        req_valid = 2'b00;
        wait_resp(ok);
        e = sb.pop_front();
        checks++; if (!ok || resp_id !== 1'b1 || resp_product !== e.prod || resp_product !== 64'h0000_0000_0001_0609) begin
            errors++; $display("FAIL tie_resp1 got %b/%h want 1/%h", resp_id, resp_product, e.prod);
        end
        handshake();
        req_valid = 2'b11;
        wait_grant(gid, ok);
        checks++; if (!ok || gid != 0) begin errors++; $display("FAIL tie_third got %0d want 0", gid); end
        sb.push_back(mk_exp(1'b0));
        @(negedge clk);
        req_valid = 2'b00;
        wait_resp(ok);
        e = sb.pop_front();
        checks++; if (!ok || resp_id !== e.id || resp_product !== e.prod) begin
            errors++; $display("FAIL tie_resp2 got %b/%h want %b/%h", resp_id, resp_product, e.id, e.prod);
        end
        handshake();
    endtask

    task automatic test_stall();
        int gid;
        bit ok;
        int bad;
        exp_t e;
        req_m     = {32'h8000_0001, 32'h0};
        req_q     = {32'h7FFF_FFFF, 32'h0};
        req_valid = 2'b10;
        wait_grant(gid, ok);
        checks++; if (!ok || gid != 1) begin errors++; $display("FAIL stall_grant got %0d want 1", gid); end
        sb.push_back(mk_exp(1'b1));
        @(negedge clk);
        req_valid = 2'b00;
        wait_resp(ok);
        e = sb.pop_front();
        checks++; if (!ok || resp_product !== e.prod) begin
            errors++; $display("FAIL stall_product got %h want %h", resp_product, e.prod);
        end
        req_valid = 2'b11;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (resp_valid !== 1'b1 || resp_id !== e.id || resp_product !== e.prod ||
                req_ready !== 2'b00 || busy !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold bad_cycles got %0d want 0", bad); end
        req_valid = 2'b00;
        handshake();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", resp_valid); end
    endtask

    task automatic test_abort();
        int gid;
        bit ok;
        int seen;
        req_m     = {32'h0, 32'h0000_1111};
        req_q     = {32'h0, 32'h0000_2222};
        req_valid = 2'b01;
        wait_grant(gid, ok);
        checks++; if (!ok || gid != 0) begin errors++; $display("FAIL abort_grant got %0d want 0", gid); end
        @(negedge clk);
        req_valid = 2'b00;
        while (cyc < g_cyc + 1 + LOAD_CYCLES + 4) @(negedge clk);
        #1;
        checks++; if (mul_load !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_in_run load=%b busy=%b want 0/1", mul_load, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || mul_load !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL abort_idle busy=%b load=%b valid=%b want 0/1/0", busy, mul_load, resp_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (resp_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_resp got %0d want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int gid;
        bit ok;
        int hs_cyc;
        exp_t e;
        hs_cyc    = 0;
        req_m     = {32'hB887_CAAF, 32'h0};
        req_q     = {32'h0000_0001, 32'h0};
        req_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            wait_grant(gid, ok);
            checks++; if (!ok || gid != 1) begin errors++; $display("FAIL b2b_grant%0d got %0d want 1", k, gid); end
            if (k > 0) begin
                checks++; if (g_cyc != hs_cyc + 1) begin
                    errors++; $display("FAIL b2b_gap%0d got %0d want %0d", k, g_cyc - hs_cyc, 1);
                end
            end
            sb.push_back(mk_exp(1'b1));
            wait_resp(ok);
            e = sb.pop_front();
            checks++; if (!ok || resp_product !== e.prod || resp_product !== 64'hFFFF_FFFF_B887_CAAF) begin
                errors++; $display("FAIL b2b_product%0d got %h want %h", k, resp_product, e.prod);
            end
            hs_cyc = r_cyc;
            handshake();
        end
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_dropped busy got %b want 0", busy); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_empty got %0d want 0", sb.size()); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have parameter LOAD_CYCLES, default 3: cycles mul_load is held high to load fresh operands.
REQ-002 SHALL have parameter MUL_CYCLES, default 17: cycles from mul_load deassertion until mul_product is valid.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  2  request valid; bit i belongs to requester i.
REQ-006 SHALL have port req_ready  output  2  one-hot grant/accept pulse per requester.
REQ-007 SHALL have port req_m  input  64  multiplicands {req1 M[31:0], req0 M[31:0]}, signed.
REQ-008 SHALL have port req_q  input  64  multipliers {req1 Q, req0 Q}, signed.
REQ-009 SHALL have port resp_valid  output  1  result available.
REQ-010 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port resp_id  output  1  index of requester owning the result.
REQ-012 SHALL have port resp_product  output  64  signed product M*Q.
REQ-013 SHALL have port mul_load  output  1  drives the shared multiplier reset/load input; high holds it in load.
REQ-014 SHALL have ports mul_m and mul_q  output  32 each  operands presented to the shared multiplier.
REQ-015 SHALL have port mul_product  input  64  shared multiplier result.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement the states IDLE, LOAD, RUN and DONE.
REQ-018 In IDLE with any req_valid bit set, SHALL grant exactly one requester, pulse its req_ready for one cycle, register its operands into mul_m and mul_q, and go to LOAD.
REQ-019 Arbitration SHALL be round-robin on a last_grant bit: when both requesters are valid, the one not equal to last_grant wins; a single valid requester always wins.
REQ-020 req_ready SHALL assert only in IDLE; no request is accepted while busy.
REQ-021 A req_valid bit that drops before it is granted SHALL have no effect.
REQ-022 mul_load SHALL be 1 in IDLE and in LOAD; LOAD SHALL last exactly LOAD_CYCLES cycles before the transition to RUN.
REQ-023 In RUN, mul_load SHALL be 0 and a counter of width clog2(MUL_CYCLES+1) SHALL count MUL_CYCLES cycles.
REQ-024 At terminal count, SHALL capture mul_product into resp_product, set resp_id to the granted requester, and go to DONE.
REQ-025 mul_m and mul_q SHALL remain stable from grant until the DONE transition.
REQ-026 In DONE, resp_valid SHALL be 1 and resp_product and resp_id SHALL be held stable until resp_ready is 1.
REQ-027 On the DONE handshake, SHALL update last_grant, deassert resp_valid and return to IDLE; a new grant occurs no earlier than the following cycle (no bypass).
REQ-028 Latency from the req_ready pulse to the first resp_valid cycle SHALL be exactly 1+LOAD_CYCLES+MUL_CYCLES cycles (21 with default parameters).
REQ-029 The product SHALL pass unmodified from mul_product; no sign or width adjustment is made in this block.

Reset
REQ-030 On reset, SHALL set state to IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_product=0, mul_m=0, mul_q=0, mul_load=1, busy=0, counter=0 and last_grant=1.
REQ-031 Reset asserted in any state, mid-operation included, SHALL abort the operation in the next cycle; no response is produced for the aborted request.

Structure
REQ-032 The package mult_share_pkg SHALL hold the state enum, the operand width (32), the product width (64) and the parameter defaults.
REQ-033 The 2-way round-robin grant logic SHALL be the sub-module rr_arbiter2, combinational, with last_grant as an input.

Verification
REQ-034 req0 only, M=0x00087234 and Q=0x00000348, with a behavioural multiplier model -> resp_id=0, resp_product=0x000000001BB6BAA0, resp_valid exactly 21 cycles after req_ready[0].
REQ-035 Both valid in the first cycle after reset, req1 M=Q=0xFFFFFEFD -> req0 served first; req1 then receives 0x0000000000010609; the following tie goes to req0.
REQ-036 resp_ready held low for 10 cycles in DONE -> resp_valid, resp_id and resp_product stable, req_ready=0, busy=1 throughout.
REQ-037 reset pulsed in cycle 5 of RUN -> next cycle IDLE, mul_load=1, resp_valid=0, and no response for the aborted request.
REQ-038 req1 continuously valid, M=0xB887CAAF and Q=0x00000001 -> back-to-back results 0xFFFFFFFFB887CAAF with exactly one IDLE cycle between the handshake and the next grant.
